reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order retirement stage of the RV32I Tomasulo core: a 16-entry circular buffer that receives instructions from the Decoder at issue and results from the ALU and LSB broadcast buses. It retires one entry per cycle in program order, driving the register-file commit port, the LSB store-commit port, and global rollback on branch/JALR misprediction. It also answers combinational operand queries for renamed registers.

## Interface
Parameters:
- ROB_SIZE, 16, entry count; power of two.
- ROB_POS_W, 4, log2(ROB_SIZE); tag width.

Ports (`clk`, `rst`, `rdy`):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; when low all state and outputs hold.
- full  out  1  count >= ROB_SIZE-1; combinational from registered count only.
- next_rob_pos  out  ROB_POS_W  tail; tag the Decoder assigns this cycle.
- issue  in  1  allocate entry at tail.
- issue_type  in  2  0 REG, 1 STORE, 2 BRANCH, 3 JALR.
- issue_rd  in  5  destination register (REG/JALR).
- issue_ready  in  1  result already known (LUI, AUIPC, JAL).
- issue_val  in  32  value when issue_ready; pc+4 for JALR.
- issue_pc  in  32  instruction PC.
- issue_pred_jump  in  1  predicted taken (BRANCH).
- alu_result  in  1  ALU broadcast valid.
- alu_rob_pos  in  ROB_POS_W  target entry.
- alu_val  in  32  result value.
- alu_jump  in  1  actual taken (BRANCH).
- alu_dest_pc  in  32  branch/JALR target.
- lsb_result  in  1  LSB broadcast valid (load data, or store ready to commit).
- lsb_rob_pos  in  ROB_POS_W  target entry.
- lsb_val  in  32  load data.
- q1_pos, q2_pos  in  ROB_POS_W  operand query tags.
- q1_ready, q2_ready  out  1  queried entry result available.
- q1_val, q2_val  out  32  queried value.
- commit_reg  out  1  register write pulse to the register file.
- commit_store  out  1  store retire pulse to the LSB.
- commit_rd  out  5  destination register.
- commit_val  out  32  value to write.
- commit_rob_pos  out  ROB_POS_W  retired entry tag.
- rollback  out  1  flush pulse.
- correct_pc  out  32  fetch redirect; valid with rollback.

## Operation
- State: head, tail (ROB_POS_W, wrap modulo ROB_SIZE), count (ROB_POS_W+1 bits). Per entry: busy, ready, type, rd, val, pc, pred_jump, jump, dest_pc.
- Issue: when issue and not rollback:
  - write entry[tail] with busy=1, ready=issue_ready, val=issue_val.
  - tail+1.
  - Issue at count==ROB_SIZE is ignored; the Decoder honours full, so this cannot occur legally.
- Writeback: alu_result or lsb_result sets ready=1 and val on a busy entry. ALU also records jump and dest_pc. A writeback to a non-busy entry is ignored. ALU and LSB writeback to different entries in the same cycle are both taken.
- Commit: if count>0 and entry[head].ready, retire head. At most one per cycle.
  - REG: commit_reg=1; commit_rd, commit_val from the entry.
  - STORE: commit_store=1.
  - BRANCH: if jump != pred_jump, rollback=1 and correct_pc = jump ? dest_pc : pc+4.
  - JALR: commit_reg=1 with val (pc+4), rollback=1, correct_pc=dest_pc.
  - On retire: busy cleared, head+1, count-1.
- Rollback: on the edge where a mispredict commits, set head=tail=count=0 and clear all busy. During the cycle rollback is high, ignore issue and writeback inputs (stale) and perform no commit.
- Count arithmetic: issue and commit in the same cycle leave count unchanged.
- Query: qN_ready = entry ready, or a same-cycle alu_result/lsb_result matching qN_pos. qN_val is the broadcast value when bypassed, otherwise the stored val.
- Reset: head, tail, count = 0. All busy = 0. Every output = 0; full = 0 and next_rob_pos = 0.

## Timing
- Issue at edge N: entry visible from cycle N+1. An issue_ready entry at head commits at edge N+1.
- Writeback at edge M: the commit pulse for that head entry is high from edge M+1. Writeback and commit never occur in the same cycle for the same entry.
- Commit outputs are registered, one-cycle pulses. They are cleared on the next enabled edge with no retire.
- rollback and correct_pc are registered and high for exactly one enabled cycle.
- rdy low: no state change; pulses hold their value (downstream is also gated by rdy).
- Reset asserted mid-operation: next edge reaches the reset state; in-flight pulses are dropped.

## Structure
- Shared macros: ROB_SIZE, ROB_POS_WID, ROB_ID_WID, DATA_WID, REG_POS_WID, and the ROB type codes.
- Flat per-field arrays with no sub-module. Query bypass is inline combinational logic.

## Test plan
- Reset, then issue REG rd=5 with issue_ready=1 and val=0x1234 -> next cycle commit_reg=1, commit_rd=5, commit_val=0x1234, commit_rob_pos=0.
- Issue 3 REG entries not ready; ALU writes back pos 2, then 0, then 1 -> commits occur in order 0, 1, 2, and 0 commits only after pos 0's writeback.
- Issue 15 entries -> full=1, next_rob_pos=15. Then retire 1 and issue 1 in the same cycle -> count stays 15 and tail wraps to 0 after the 16th issue.
- BRANCH at pc=0x100 with pred_jump=0; ALU jump=1, dest_pc=0x200 -> rollback=1 and correct_pc=0x200 for one cycle; count=0 afterward; a younger writeback in the rollback cycle is ignored.
- JALR at pc=0x40 with val=0x44; ALU dest_pc=0x80 -> commit_reg=1 with commit_val=0x44, rollback=1, correct_pc=0x80.
- ALU broadcast pos 3 with val=7 while q1_pos=3 -> q1_ready=1 and q1_val=7 in the same cycle. With rdy=0 held for 3 cycles, head, tail and count are unchanged.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared widths and entry type codes for the reorder buffer
package reorder_buffer_pkg;
  localparam int ROB_SIZE = 16;
  localparam int ROB_POS_WID = 4;
  localparam int ROB_ID_WID = ROB_POS_WID + 1;
  localparam int DATA_WID = 32;
  localparam int REG_POS_WID = 5;
  typedef enum logic [1:0] {
    ROB_REG = 2'd0,
    ROB_STORE = 2'd1,
    ROB_BRANCH = 2'd2,
    ROB_JALR = 2'd3
  } rob_type_e;
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement, writeback capture, operand bypass and mispredict rollback
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE = reorder_buffer_pkg::ROB_SIZE,
  parameter int ROB_POS_W = reorder_buffer_pkg::ROB_POS_WID
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  output logic                   full,
  output logic [ROB_POS_W-1:0]   next_rob_pos,
  input  logic                   issue,
  input  logic [1:0]             issue_type,
  input  logic [REG_POS_WID-1:0] issue_rd,
  input  logic                   issue_ready,
  input  logic [DATA_WID-1:0]    issue_val,
  input  logic [DATA_WID-1:0]    issue_pc,
  input  logic                   issue_pred_jump,
  input  logic                   alu_result,
  input  logic [ROB_POS_W-1:0]   alu_rob_pos,
  input  logic [DATA_WID-1:0]    alu_val,
  input  logic                   alu_jump,
  input  logic [DATA_WID-1:0]    alu_dest_pc,
  input  logic                   lsb_result,
  input  logic [ROB_POS_W-1:0]   lsb_rob_pos,
  input  logic [DATA_WID-1:0]    lsb_val,
  input  logic [ROB_POS_W-1:0]   q1_pos,
  input  logic [ROB_POS_W-1:0]   q2_pos,
  output logic                   q1_ready,
  output logic                   q2_ready,
  output logic [DATA_WID-1:0]    q1_val,
  output logic [DATA_WID-1:0]    q2_val,
  output logic                   commit_reg,
  output logic                   commit_store,
  output logic [REG_POS_WID-1:0] commit_rd,
  output logic [DATA_WID-1:0]    commit_val,
  output logic [ROB_POS_W-1:0]   commit_rob_pos,
  output logic                   rollback,
  output logic [DATA_WID-1:0]    correct_pc
);
  localparam logic [ROB_POS_W:0] full_at = (ROB_POS_W + 1)'(ROB_SIZE - 1);
  localparam logic [ROB_POS_W:0] cap = (ROB_POS_W + 1)'(ROB_SIZE);
  logic [ROB_POS_W-1:0] head, tail;
  logic [ROB_POS_W:0] count;
  logic busy [ROB_SIZE];
  logic ready [ROB_SIZE];
  logic pred_jump [ROB_SIZE];
  logic jump [ROB_SIZE];
  rob_type_e typ [ROB_SIZE];
  logic [REG_POS_WID-1:0] rd [ROB_SIZE];
  logic [DATA_WID-1:0] val [ROB_SIZE];
  logic [DATA_WID-1:0] pc [ROB_SIZE];
  logic [DATA_WID-1:0] dest_pc [ROB_SIZE];
  logic do_issue, do_commit, mispredict;
  logic q1_alu, q1_lsb, q2_alu, q2_lsb;
  logic [DATA_WID-1:0] head_pc4;
  assign full = count >= full_at;
  assign next_rob_pos = tail;
  always_comb begin
    do_issue = issue && !rollback && count != cap;
    do_commit = !rollback && count != '0 && ready[head];
    head_pc4 = pc[head] + 32'd4;
    mispredict = do_commit && (typ[head] == ROB_JALR || (typ[head] == ROB_BRANCH && jump[head] != pred_jump[head]));
    q1_alu = alu_result && alu_rob_pos == q1_pos;
    q1_lsb = lsb_result && lsb_rob_pos == q1_pos;
    q2_alu = alu_result && alu_rob_pos == q2_pos;
    q2_lsb = lsb_result && lsb_rob_pos == q2_pos;
    q1_ready = ready[q1_pos] || q1_alu || q1_lsb;
    q2_ready = ready[q2_pos] || q2_alu || q2_lsb;
    q1_val = q1_alu ? alu_val : q1_lsb ? lsb_val : val[q1_pos];
    q2_val = q2_alu ? alu_val : q2_lsb ? lsb_val : val[q2_pos];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy[i] <= 1'b0;
        ready[i] <= 1'b0;
        pred_jump[i] <= 1'b0;
        jump[i] <= 1'b0;
        typ[i] <= ROB_REG;
        rd[i] <= '0;
        val[i] <= '0;
        pc[i] <= '0;
        dest_pc[i] <= '0;
      end
      commit_reg <= 1'b0;
      commit_store <= 1'b0;
      commit_rd <= '0;
      commit_val <= '0;
      commit_rob_pos <= '0;
      rollback <= 1'b0;
      correct_pc <= '0;
    end else if (rdy) begin
      if (do_issue) begin
        busy[tail] <= 1'b1;
        ready[tail] <= issue_ready;
        typ[tail] <= rob_type_e'(issue_type);
        rd[tail] <= issue_rd;
        val[tail] <= issue_val;
        pc[tail] <= issue_pc;
        pred_jump[tail] <= issue_pred_jump;
        jump[tail] <= 1'b0;
        dest_pc[tail] <= '0;
        tail <= tail + ROB_POS_W'(1);
      end
      if (!rollback && alu_result && busy[alu_rob_pos]) begin
        ready[alu_rob_pos] <= 1'b1;
        val[alu_rob_pos] <= alu_val;
        jump[alu_rob_pos] <= alu_jump;
        dest_pc[alu_rob_pos] <= alu_dest_pc;
      end
      if (!rollback && lsb_result && busy[lsb_rob_pos]) begin
        ready[lsb_rob_pos] <= 1'b1;
        val[lsb_rob_pos] <= lsb_val;
      end
      commit_reg <= do_commit && (typ[head] == ROB_REG || typ[head] == ROB_JALR);
      commit_store <= do_commit && typ[head] == ROB_STORE;
      rollback <= mispredict;
      if (do_commit) begin
        commit_rd <= rd[head];
        commit_val <= val[head];
        commit_rob_pos <= head;
        busy[head] <= 1'b0;
        head <= head + ROB_POS_W'(1);
      end
      if (mispredict) correct_pc <= typ[head] == ROB_BRANCH && !jump[head] ? head_pc4 : dest_pc[head];
      count <= count + (ROB_POS_W + 1)'(do_issue) - (ROB_POS_W + 1)'(do_commit);
      if (mispredict) begin
        head <= '0;
        tail <= '0;
        count <= '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
          busy[i] <= 1'b0;
          ready[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and randomized checking of reorder_buffer against a queue-based model
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst, rdy, full, issue, issue_ready, issue_pred_jump;
  logic [3:0] next_rob_pos, alu_rob_pos, lsb_rob_pos, q1_pos, q2_pos, commit_rob_pos;
  logic [1:0] issue_type;
  logic [4:0] issue_rd, commit_rd;
  logic [31:0] issue_val, issue_pc, alu_val, alu_dest_pc, lsb_val, q1_val, q2_val, commit_val, correct_pc;
  logic alu_result, alu_jump, lsb_result, q1_ready, q2_ready, commit_reg, commit_store, rollback;
  always #5 clk = ~clk;
  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy), .full(full), .next_rob_pos(next_rob_pos),
    .issue(issue), .issue_type(issue_type), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .issue_val(issue_val), .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump),
    .alu_result(alu_result), .alu_rob_pos(alu_rob_pos), .alu_val(alu_val), .alu_jump(alu_jump),
    .alu_dest_pc(alu_dest_pc), .lsb_result(lsb_result), .lsb_rob_pos(lsb_rob_pos), .lsb_val(lsb_val),
    .q1_pos(q1_pos), .q2_pos(q2_pos), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val), .commit_reg(commit_reg), .commit_store(commit_store),
    .commit_rd(commit_rd), .commit_val(commit_val), .commit_rob_pos(commit_rob_pos),
    .rollback(rollback), .correct_pc(correct_pc)
  );
  typedef struct {
    int tag;
    int typ;
    logic [4:0] rd;
    bit done;
    logic [31:0] val;
    logic [31:0] pc;
    bit pred;
    bit jmp;
    logic [31:0] dst;
  } ent_t;
  ent_t rob_q[$];
  int m_tail, m_pos;
  bit m_rb, m_creg, m_cst;
  logic [4:0] m_rd;
  logic [31:0] m_val, m_cpc;
  int n_tests, n_fail;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    rob_q.delete();
    m_tail = 0;
    m_rb = 0;
    m_creg = 0;
    m_cst = 0;
    m_rd = '0;
    m_val = '0;
    m_cpc = '0;
    m_pos = 0;
  endtask
  task automatic model_step();
    ent_t e;
    bit mis = 0;
    int sz0 = rob_q.size();
    if (m_rb) begin
      m_rb = 0;
      m_creg = 0;
      m_cst = 0;
      return;
    end
    m_creg = 0;
    m_cst = 0;
    if (sz0 > 0 && rob_q[0].done) begin
      e = rob_q.pop_front();
      m_creg = e.typ == 0 || e.typ == 3;
      m_cst = e.typ == 1;
      m_rd = e.rd;
      m_val = e.val;
      m_pos = e.tag;
      mis = e.typ == 3 || (e.typ == 2 && e.jmp != e.pred);
      if (mis) m_cpc = (e.typ == 2 && !e.jmp) ? e.pc + 32'd4 : e.dst;
    end
    foreach (rob_q[i]) begin
      if (alu_result && rob_q[i].tag == int'(alu_rob_pos)) begin
        rob_q[i].done = 1;
        rob_q[i].val = alu_val;
        rob_q[i].jmp = alu_jump;
        rob_q[i].dst = alu_dest_pc;
      end
      if (lsb_result && rob_q[i].tag == int'(lsb_rob_pos)) begin
        rob_q[i].done = 1;
        rob_q[i].val = lsb_val;
      end
    end
    if (issue && sz0 < 16) begin
      e = '{tag: m_tail, typ: int'(issue_type), rd: issue_rd, done: issue_ready, val: issue_val,
            pc: issue_pc, pred: issue_pred_jump, jmp: 0, dst: '0};
      rob_q.push_back(e);
      m_tail = (m_tail + 1) % 16;
    end
    if (mis) begin
      rob_q.delete();
      m_tail = 0;
    end
    m_rb = mis;
  endtask
  task automatic chk_query(input string tag, input logic [3:0] pos, input logic r, input logic [31:0] v);
    bit known = 0;
    bit er = 0;
    logic [31:0] ev = '0;
    foreach (rob_q[i]) if (rob_q[i].tag == int'(pos)) begin
      known = 1;
      er = rob_q[i].done;
      ev = rob_q[i].val;
    end
    if (lsb_result && lsb_rob_pos == pos) begin
      known = 1;
      er = 1;
      ev = lsb_val;
    end
    if (alu_result && alu_rob_pos == pos) begin
      known = 1;
      er = 1;
      ev = alu_val;
    end
    if (known) begin
      chk({tag, "_ready"}, 32'(r), 32'(er));
      if (er) chk({tag, "_val"}, v, ev);
    end
  endtask
  task automatic tick();
    #1;
    chk_query("q1", q1_pos, q1_ready, q1_val);
    chk_query("q2", q2_pos, q2_ready, q2_val);
    @(posedge clk);
    if (rst) model_reset();
    else if (rdy) model_step();
    #1;
    chk("commit_reg", 32'(commit_reg), 32'(m_creg));
    chk("commit_store", 32'(commit_store), 32'(m_cst));
    chk("rollback", 32'(rollback), 32'(m_rb));
    chk("full", 32'(full), 32'(rob_q.size() >= 15));
    chk("next_rob_pos", 32'(next_rob_pos), 32'(m_tail));
    if (m_creg) begin
      chk("commit_rd", 32'(commit_rd), 32'(m_rd));
      chk("commit_val", commit_val, m_val);
    end
    if (m_creg || m_cst) chk("commit_rob_pos", 32'(commit_rob_pos), 32'(m_pos));
    if (m_rb) chk("correct_pc", correct_pc, m_cpc);
  endtask
  task automatic idle();
    rst = 0;
    rdy = 1;
    issue = 0;
    alu_result = 0;
    lsb_result = 0;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask
  task automatic put(input int t, input logic [4:0] d, input bit r, input logic [31:0] v, input logic [31:0] p, input bit pj);
    issue = 1;
    issue_type = 2'(t);
    issue_rd = d;
    issue_ready = r;
    issue_val = v;
    issue_pc = p;
    issue_pred_jump = pj;
    tick();
    issue = 0;
  endtask
  task automatic wb_alu(input logic [3:0] p, input logic [31:0] v, input bit j, input logic [31:0] d);
    alu_result = 1;
    alu_rob_pos = p;
    alu_val = v;
    alu_jump = j;
    alu_dest_pc = d;
    tick();
    alu_result = 0;
  endtask
  task automatic rand_inputs();
    int cand[$];
    int r, a, b;
    rst = $urandom_range(0, 499) == 0;
    rdy = $urandom_range(0, 9) != 0;
    issue = rob_q.size() < 15 && $urandom_range(0, 99) < 50;
    r = $urandom_range(0, 9);
    issue_type = r < 5 ? 2'd0 : r < 7 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
    issue_rd = 5'($urandom);
    issue_pc = $urandom & 32'hffff_fffc;
    issue_val = issue_type == 2'd3 ? issue_pc + 32'd4 : $urandom;
    issue_ready = issue_type == 2'd0 && $urandom_range(0, 2) == 0;
    issue_pred_jump = 1'($urandom);
    alu_val = $urandom;
    alu_jump = 1'($urandom);
    alu_dest_pc = $urandom & 32'hffff_fffc;
    lsb_val = $urandom;
    q1_pos = 4'($urandom);
    q2_pos = 4'($urandom);
    alu_result = 0;
    lsb_result = 0;
    foreach (rob_q[i]) if (!rob_q[i].done) cand.push_back(rob_q[i].tag);
    if (m_rb) begin
      alu_result = 1'($urandom);
      lsb_result = 1'($urandom);
      alu_rob_pos = 4'($urandom);
      lsb_rob_pos = alu_rob_pos + 4'd1;
    end else if (cand.size() > 0) begin
      a = $urandom_range(0, cand.size() - 1);
      alu_result = $urandom_range(0, 2) == 0;
      alu_rob_pos = 4'(cand[a]);
      if (cand.size() > 1) begin
        b = $urandom_range(0, cand.size() - 2);
        if (b >= a) b++;
        lsb_result = $urandom_range(0, 3) == 0;
        lsb_rob_pos = 4'(cand[b]);
      end
    end
  endtask
  initial begin
    n_tests = 0;
    n_fail = 0;
    model_reset();
    idle();
    {issue_type, issue_rd, issue_ready, issue_val, issue_pc, issue_pred_jump} = '0;
    {alu_rob_pos, alu_val, alu_jump, alu_dest_pc, lsb_rob_pos, lsb_val, q1_pos, q2_pos} = '0;
    do_reset();
    do_reset();
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_next_rob_pos", 32'(next_rob_pos), 32'd0);
    chk("rst_commit_reg", 32'(commit_reg), 32'd0);
    chk("rst_rollback", 32'(rollback), 32'd0);
    chk("rst_commit_val", commit_val, 32'd0);
    chk("rst_correct_pc", correct_pc, 32'd0);
    put(0, 5'd5, 1, 32'h1234, 32'h0, 0);
    tick();
    chk("t1_commit_reg", 32'(commit_reg), 32'd1);
    chk("t1_commit_rd", 32'(commit_rd), 32'd5);
    chk("t1_commit_val", commit_val, 32'h1234);
    chk("t1_commit_rob_pos", 32'(commit_rob_pos), 32'd0);
    do_reset();
    for (int i = 0; i < 3; i++) put(0, 5'(i + 1), 0, 32'h0, 32'(i * 4), 0);
    wb_alu(4'd2, 32'h22, 0, 32'h0);
    tick();
    chk("t2_wait_head", 32'(commit_reg), 32'd0);
    wb_alu(4'd0, 32'h20, 0, 32'h0);
    chk("t2_no_commit_same_edge", 32'(commit_reg), 32'd0);
    wb_alu(4'd1, 32'h21, 0, 32'h0);
    chk("t2_first_pos", 32'(commit_rob_pos), 32'd0);
    tick();
    chk("t2_second_pos", 32'(commit_rob_pos), 32'd1);
    tick();
    chk("t2_third_pos", 32'(commit_rob_pos), 32'd2);
    chk("t2_third_val", commit_val, 32'h22);
    do_reset();
    for (int i = 0; i < 15; i++) put(0, 5'd3, 0, 32'h0, 32'(i * 4), 0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_next_rob_pos", 32'(next_rob_pos), 32'd15);
    wb_alu(4'd0, 32'h77, 0, 32'h0);
    put(0, 5'd4, 0, 32'h0, 32'h3c, 0);
    chk("t3_commit_reg", 32'(commit_reg), 32'd1);
    chk("t3_tail_wrap", 32'(next_rob_pos), 32'd0);
    chk("t3_still_full", 32'(full), 32'd1);
    do_reset();
    put(2, 5'd0, 0, 32'h0, 32'h100, 0);
    put(0, 5'd1, 0, 32'h0, 32'h104, 0);
    wb_alu(4'd0, 32'h0, 1, 32'h200);
    tick();
    chk("t4_rollback", 32'(rollback), 32'd1);
    chk("t4_correct_pc", correct_pc, 32'h200);
    alu_result = 1;
    alu_rob_pos = 4'd1;
    alu_val = 32'h99;
    put(0, 5'd2, 1, 32'h55, 32'h200, 0);
    alu_result = 0;
    chk("t4_rollback_one_cycle", 32'(rollback), 32'd0);
    chk("t4_empty_tail", 32'(next_rob_pos), 32'd0);
    tick();
    chk("t4_stale_ignored", 32'(commit_reg), 32'd0);
    do_reset();
    put(3, 5'd1, 0, 32'h44, 32'h40, 0);
    wb_alu(4'd0, 32'h44, 0, 32'h80);
    tick();
    chk("t5_commit_reg", 32'(commit_reg), 32'd1);
    chk("t5_commit_val", commit_val, 32'h44);
    chk("t5_rollback", 32'(rollback), 32'd1);
    chk("t5_correct_pc", correct_pc, 32'h80);
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) put(0, 5'd6, 0, 32'h0, 32'(i * 4), 0);
    alu_result = 1;
    alu_rob_pos = 4'd3;
    alu_val = 32'd7;
    q1_pos = 4'd3;
    #1;
    chk("t6_q1_ready", 32'(q1_ready), 32'd1);
    chk("t6_q1_val", q1_val, 32'd7);
    tick();
    alu_result = 0;
    rdy = 0;
    issue = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_hold_tail", 32'(next_rob_pos), 32'd4);
    end
    idle();
    tick();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rand_inputs();
      tick();
    end
    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
